// File: rtl/regfile_write_sequencer_pkg.sv
// Shared constants, state encoding and register filter for the register file write sequencer.
package regfile_write_sequencer_pkg;

  localparam int NUM_REQ     = 3;
  localparam int NUM_REGS    = 31;
  localparam int INDEX_WIDTH = 5;
  localparam int DATA_WIDTH  = 32;
  localparam int REQ_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [INDEX_WIDTH-1:0] REG_ZERO = INDEX_WIDTH'(0);
  localparam logic [INDEX_WIDTH-1:0] REG_PC   = INDEX_WIDTH'(31);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // r0 is hardwired zero and r31 is the PC, so neither has storage behind it.
  function automatic logic isStoredReg(input logic [INDEX_WIDTH-1:0] idx);
    return (idx != REG_ZERO) && (idx != REG_PC);
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Writeback request bus plus register file write port of the sequencer.
interface regfile_write_sequencer_if;
  import regfile_write_sequencer_pkg::*;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_value_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [INDEX_WIDTH-1:0]         select_write_o;
  logic                           write_enable_o;
  logic [DATA_WIDTH-1:0]          write_value_o;
  logic                           init_done_o;

  modport slave (
    input  req_valid_i, req_index_i, req_value_i,
    output req_ready_o, select_write_o, write_enable_o, write_value_o, init_done_o
  );

  modport master (
    output req_valid_i, req_index_i, req_value_i,
    input  req_ready_o, select_write_o, write_enable_o, write_value_o, init_done_o
  );

endinterface

// File: rtl/regfile_write_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward from ptr_i.
module regfile_write_sequencer_rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] grantIdx_o,
  output logic             anyGrant_o
);

  int               cand;
  logic [PTR_W-1:0] candIdx;

  // Walk from the farthest offset down so the nearest requester to ptr_i wins.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyGrant_o = 1'b0;
    cand       = 0;
    candIdx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand    = (int'(ptr_i) + k) % N;
      candIdx = PTR_W'(cand);
      if (req_i[candIdx]) begin
        grant_o          = '0;
        grant_o[candIdx] = 1'b1;
        grantIdx_o       = candIdx;
        anyGrant_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register file write port: clears r0..r30 after reset, then arbitrates writeback requesters.
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
(
  input logic                       clock_i,
  input logic                       reset_i,
  regfile_write_sequencer_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] clearIdx_q, clearIdx_d;
  logic [REQ_PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [INDEX_WIDTH-1:0] select_q, select_d;
  logic [DATA_WIDTH-1:0]  value_q, value_d;
  logic                   enable_q, enable_d;
  logic                   done_q, done_d;

  logic [NUM_REQ-1:0]     grant;
  logic [REQ_PTR_W-1:0]   grantIdx;
  logic                   anyGrant;
  logic [INDEX_WIDTH-1:0] grantIndex;
  logic [DATA_WIDTH-1:0]  grantValue;

  regfile_write_sequencer_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (REQ_PTR_W)
  ) u_arbiter (
    .req_i      (bus.req_valid_i),
    .ptr_i      (rrPtr_q),
    .grant_o    (grant),
    .grantIdx_o (grantIdx),
    .anyGrant_o (anyGrant)
  );

  assign grantIndex = bus.req_index_i[grantIdx*INDEX_WIDTH +: INDEX_WIDTH];
  assign grantValue = bus.req_value_i[grantIdx*DATA_WIDTH +: DATA_WIDTH];

  // Ready is masked by reset too, since state_q may still read RUN while reset is held.
  assign bus.req_ready_o    = ((state_q == ST_RUN) && !reset_i) ? grant : '0;
  assign bus.select_write_o = select_q;
  assign bus.write_enable_o = enable_q;
  assign bus.write_value_o  = value_q;
  assign bus.init_done_o    = done_q;

  always_comb begin
    state_d    = state_q;
    clearIdx_d = clearIdx_q;
    rrPtr_d    = rrPtr_q;
    select_d   = select_q;
    value_d    = value_q;
    enable_d   = 1'b0;
    done_d     = done_q;
    case (state_q)
      ST_INIT: begin
        select_d   = clearIdx_q;
        value_d    = '0;
        enable_d   = 1'b1;
        clearIdx_d = clearIdx_q + 1'b1;
        if (clearIdx_q == INDEX_WIDTH'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (anyGrant) begin
          rrPtr_d = (grantIdx == REQ_PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
          // Writes to r0/r31 still handshake but never reach the port.
          if (isStoredReg(grantIndex)) begin
            select_d = grantIndex;
            value_d  = grantValue;
            enable_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_INIT;
      clearIdx_q <= '0;
      rrPtr_q    <= '0;
      select_q   <= '0;
      value_q    <= '0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearIdx_q <= clearIdx_d;
      rrPtr_q    <= rrPtr_d;
      select_q   <= select_d;
      value_q    <= value_d;
      enable_q   <= enable_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench: a cycle-level reference model queues expected writes, a monitor pops and compares them.
module tb_regfile_write_sequencer;
  import regfile_write_sequencer_pkg::*;

  typedef struct {
    int          cyc;
    logic [4:0]  idx;
    logic [31:0] val;
  } wr_t;

  logic clock_i;
  logic reset_i;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t  expQ[$];
  bit   expDone[int];
  bit   expRst[int];

  bit   mRun   = 0;
  bit   mDone  = 0;
  int   mClear = 0;
  int   mPtr   = 0;

  regfile_write_sequencer_if bus();

  regfile_write_sequencer dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  always @(posedge clock_i) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: decides, from the inputs seen now, what the next edge must produce.
  always @(negedge clock_i) begin
    int          g;
    int          n;
    logic [2:0]  expReady;
    logic [4:0]  idx;
    g = -1;
    if (!reset_i && mRun) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        n = (mPtr + k) % NUM_REQ;
        if (g < 0 && bus.req_valid_i[n]) g = n;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checks++;
    if (bus.req_ready_o !== expReady) begin
      errors++;
      $display("[TB] FAIL ready cyc=%0d got %b wanted %b", cyc, bus.req_ready_o, expReady);
    end
    if (reset_i) begin
      mRun = 0; mDone = 0; mClear = 0; mPtr = 0;
      expRst[cyc + 1] = 1'b1;
    end else if (!mRun) begin
      expQ.push_back('{cyc + 1, 5'(mClear), 32'h0});
      if (mClear == NUM_REGS - 1) begin
        mRun  = 1;
        mDone = 1;
      end
      mClear++;
    end else if (g >= 0) begin
      mPtr = (g + 1) % NUM_REQ;
      idx  = bus.req_index_i[g*5 +: 5];
      if (idx != 5'd0 && idx != 5'd31)
        expQ.push_back('{cyc + 1, idx, bus.req_value_i[g*32 +: 32]});
    end
    expDone[cyc + 1] = mDone;
  end

  task automatic checkOutput();
    wr_t wr;
    if (expDone.exists(cyc)) begin
      checks++;
      if (bus.init_done_o !== expDone[cyc]) begin
        errors++;
        $display("[TB] FAIL init_done cyc=%0d got %b wanted %b", cyc, bus.init_done_o, expDone[cyc]);
      end
    end
    if (expRst.exists(cyc)) begin
      checks++;
      if (bus.select_write_o !== 5'd0 || bus.write_value_o !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_port cyc=%0d got sel=%0d val=%h wanted 0/0",
                 cyc, bus.select_write_o, bus.write_value_o);
      end
    end
    if (bus.write_enable_o === 1'b1) begin
      checks++;
      if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
        errors++;
        $display("[TB] FAIL unexpected_write cyc=%0d got sel=%0d val=%h wanted no write",
                 cyc, bus.select_write_o, bus.write_value_o);
      end else begin
        wr = expQ.pop_front();
        if (bus.select_write_o !== wr.idx || bus.write_value_o !== wr.val) begin
          errors++;
          $display("[TB] FAIL write cyc=%0d got sel=%0d val=%h wanted sel=%0d val=%h",
                   cyc, bus.select_write_o, bus.write_value_o, wr.idx, wr.val);
        end
      end
    end else if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
      checks++;
      errors++;
      wr = expQ.pop_front();
      $display("[TB] FAIL missing_write cyc=%0d got enable=%b wanted sel=%0d val=%h",
               cyc, bus.write_enable_o, wr.idx, wr.val);
    end
  endtask

  always @(negedge clock_i) if (cyc > 0) checkOutput();

  task automatic doReset(input int n);
    reset_i = 1'b1;
    repeat (n) @(posedge clock_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic waitInit();
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock_i);
      if (bus.init_done_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL init_timeout got init_done=0 wanted 1 within 40 cycles");
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic issueOne(input int n, input logic [4:0] idx, input logic [31:0] val);
    bit done = 0;
    bus.req_valid_i[n]        = 1'b1;
    bus.req_index_i[n*5 +: 5]  = idx;
    bus.req_value_i[n*32 +: 32] = val;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock_i);
      if (bus.req_ready_o[n] === 1'b1) done = 1;
      @(posedge clock_i);
      #1;
    end
    bus.req_valid_i[n] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL handshake_timeout req=%0d got no ready wanted ready within 60 cycles", n);
    end
  endtask

  // mode 0: drain held requests, 1: random traffic, 2: keep every requester valid.
  task automatic applyStimulus(input int cycles, input int mode);
    logic [2:0] hs;
    logic [4:0] idx;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock_i);
      hs = bus.req_ready_o & bus.req_valid_i;
      @(posedge clock_i);
      #1;
      for (int n = 0; n < NUM_REQ; n++) begin
        if (!bus.req_valid_i[n] || hs[n]) begin
          case (mode)
            0:       bus.req_valid_i[n] = 1'b0;
            1:       bus.req_valid_i[n] = 1'($urandom_range(0, 1));
            default: bus.req_valid_i[n] = 1'b1;
          endcase
          idx = 5'($urandom);
          if ($urandom_range(0, 7) == 0) idx = $urandom_range(0, 1) ? 5'd31 : 5'd0;
          bus.req_index_i[n*5 +: 5]   = idx;
          bus.req_value_i[n*32 +: 32] = $urandom;
        end
      end
    end
  endtask

  initial begin
    reset_i         = 1'b1;
    bus.req_valid_i = '0;
    bus.req_index_i = '0;
    bus.req_value_i = '0;

    $display("[TB] reset and full clear sequence");
    doReset(2);
    waitInit();
    applyStimulus(3, 0);

    $display("[TB] request held across the clear");
    bus.req_valid_i[0]   = 1'b1;
    bus.req_index_i[4:0] = 5'd3;
    bus.req_value_i[31:0] = 32'h1234_5678;
    doReset(1);
    issueOne(0, 5'd3, 32'h1234_5678);
    applyStimulus(3, 0);

    $display("[TB] single request and round robin");
    issueOne(1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(6, 2);
    applyStimulus(6, 0);

    $display("[TB] filtered writes to r0 and r31");
    issueOne(0, 5'd0, 32'hFFFF_FFFF);
    issueOne(0, 5'd31, 32'hFFFF_FFFF);
    applyStimulus(3, 0);

    $display("[TB] reset in the middle of the clear");
    doReset(1);
    repeat (13) @(posedge clock_i);
    #1 reset_i = 1'b1;
    @(posedge clock_i);
    #1 reset_i = 1'b0;
    waitInit();

    $display("[TB] random traffic");
    applyStimulus(300, 1);
    doReset(1);
    applyStimulus(20, 1);
    waitInit();
    applyStimulus(200, 1);
    applyStimulus(10, 0);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_writes got %0d pending wanted 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
